// File: rtl/vga_layer_sequencer_pkg.sv
// Shared types and constants for the VGA layer sequencer and the game logic around it.
package vga_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LAUNCH,
        ST_DRAW,
        ST_DONE
    } seq_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [7:0] DEFAULT_KEY_COLOUR = 8'h09;

    typedef enum logic [1:0] {LOC_TITLE, LOC_FIELD, LOC_SHOP, LOC_END}     location_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_MOVE, ACT_FIRE, ACT_USE}       action_t;
    typedef enum logic [1:0] {GS_MENU, GS_PLAY, GS_PAUSE, GS_OVER}         game_state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Watchdog counter width; kept at least one bit so a disabled watchdog still elaborates.
    function automatic int tmr_w(input int t);
        return (t <= 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/vga_layer_sequencer_if.sv
// Engine-side launch/pixel bus plus the registered pixel port toward the VGA adapter.
interface vga_layer_sequencer_if #(
    parameter int NUM_LAYERS   = 4,
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 8
);
    logic [NUM_LAYERS-1:0]                   layer_start;
    logic [NUM_LAYERS-1:0][X_WIDTH-1:0]      layer_x;
    logic [NUM_LAYERS-1:0][Y_WIDTH-1:0]      layer_y;
    logic [NUM_LAYERS-1:0][COLOUR_WIDTH-1:0] layer_colour;
    logic [NUM_LAYERS-1:0]                   layer_write;
    logic [NUM_LAYERS-1:0]                   layer_done;

    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [COLOUR_WIDTH-1:0] colour;
    logic                    writeEn;

    modport master (
        output layer_start, x, y, colour, writeEn,
        input  layer_x, layer_y, layer_colour, layer_write, layer_done
    );

    modport slave (
        input  layer_start, x, y, colour, writeEn,
        output layer_x, layer_y, layer_colour, layer_write, layer_done
    );
endinterface

// File: rtl/vga_layer_sequencer_prio_enc.sv
// Lowest-set-bit priority encoder: picks the next layer to draw from the pending mask.
module vga_layer_sequencer_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    output logic          any,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        any = |mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/vga_layer_sequencer.sv
// Frame sequencer: launches enabled draw engines lowest-layer first and forwards their pixels.
module vga_layer_sequencer
    import vga_layer_sequencer_pkg::*;
#(
    parameter int                      NUM_LAYERS   = 4,
    parameter int                      X_WIDTH      = 8,
    parameter int                      Y_WIDTH      = 7,
    parameter int                      COLOUR_WIDTH = 8,
    parameter logic [COLOUR_WIDTH-1:0] KEY_COLOUR   = COLOUR_WIDTH'(DEFAULT_KEY_COLOUR),
    parameter bit                      KEY_LAYER0   = 1'b0,
    parameter int                      TIMEOUT      = 32768,
    localparam int                     IDX_W        = idx_w(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_LAYERS-1:0] layer_en,
    vga_layer_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      active_layer,
    output logic [NUM_LAYERS-1:0] timeout_err
);
    localparam int TW = tmr_w(TIMEOUT);

    seq_state_t            state, nxt;
    logic [NUM_LAYERS-1:0] mask;
    logic [TW-1:0]         timer;
    logic                  anyPending;
    logic [IDX_W-1:0]      lowIdx;
    logic                  curDone, curWrite, tmo, keyed, fwd;
    logic [COLOUR_WIDTH-1:0] curColour;

    vga_layer_sequencer_prio_enc #(.N(NUM_LAYERS), .IW(IDX_W)) u_prio (
        .mask (mask),
        .any  (anyPending),
        .idx  (lowIdx)
    );

    assign curDone   = bus.layer_done[active_layer];
    assign curWrite  = bus.layer_write[active_layer];
    assign curColour = bus.layer_colour[active_layer];

    generate
        if (TIMEOUT != 0) begin : g_wdog
            assign tmo = (timer == TW'(TIMEOUT - 1));
        end else begin : g_nowdog
            assign tmo = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            mask         <= '0;
            timer        <= '0;
            timeout_err  <= '0;
            active_layer <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE: if (start) begin
                    mask        <= layer_en;
                    timeout_err <= '0;
                end
                ST_SCAN:   if (anyPending) active_layer <= lowIdx;
                ST_LAUNCH: timer <= '0;
                ST_DRAW: begin
                    if (timer != '1) timer <= timer + 1'b1;
                    // A genuine done wins over a watchdog expiry landing on the same cycle.
                    if (curDone) begin
                        mask[active_layer] <= 1'b0;
                    end else if (tmo) begin
                        mask[active_layer]        <= 1'b0;
                        timeout_err[active_layer] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt             = state;
        busy            = 1'b1;
        done            = 1'b0;
        bus.layer_start = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) nxt = ST_SCAN;
            end
            ST_SCAN:   nxt = anyPending ? ST_LAUNCH : ST_DONE;
            ST_LAUNCH: begin
                bus.layer_start[active_layer] = 1'b1;
                nxt = ST_DRAW;
            end
            ST_DRAW:   if (curDone || tmo) nxt = ST_SCAN;
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) nxt = ST_IDLE;
            end
            default:   nxt = ST_IDLE;
        endcase
    end

    // Background layer is opaque unless KEY_LAYER0 asks for keying there too.
    assign keyed = (active_layer != '0) || KEY_LAYER0;
    assign fwd   = curWrite && (state == ST_DRAW) && !(keyed && (curColour == KEY_COLOUR));

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.x       <= '0;
            bus.y       <= '0;
            bus.colour  <= '0;
            bus.writeEn <= 1'b0;
        end else begin
            bus.writeEn <= fwd;
            if (fwd) begin
                bus.x      <= bus.layer_x[active_layer];
                bus.y      <= bus.layer_y[active_layer];
                bus.colour <= curColour;
            end
        end
    end

endmodule

// File: tb/tb_vga_layer_sequencer.sv
// Directed bench for vga_layer_sequencer with a scripted engine model per layer.
module tb_vga_layer_sequencer;
    localparam int NL = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] c;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NL-1:0] layer_en = '0;
    logic          busy, done;
    logic [1:0]    active_layer;
    logic [NL-1:0] timeout_err;

    vga_layer_sequencer_if #(.NUM_LAYERS(NL), .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(8)) bus ();

    vga_layer_sequencer #(
        .NUM_LAYERS(NL), .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(8),
        .KEY_COLOUR(8'h09), .KEY_LAYER0(1'b0), .TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .layer_en     (layer_en),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .active_layer (active_layer),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // engine script
    int         npx[NL];
    bit         hang[NL];
    bit         dlast[NL];
    logic [7:0] ctab[NL][8];
    bit         run[NL];
    int         k[NL];

    logic [NL-1:0] e_wr = '0, e_dn = '0, stray_wr = '0, stray_dn = '0;
    logic [7:0]    e_x[NL];
    logic [6:0]    e_y[NL];
    logic [7:0]    e_c[NL];

    assign bus.layer_write = e_wr | stray_wr;
    assign bus.layer_done  = e_dn | stray_dn;
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            bus.layer_x[i]      = e_x[i];
            bus.layer_y[i]      = e_y[i];
            bus.layer_colour[i] = e_c[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            e_wr[i] <= 1'b0;
            e_dn[i] <= 1'b0;
            if (reset) begin
                run[i] <= 1'b0;
            end else if (bus.layer_start[i]) begin
                run[i] <= 1'b1;
                k[i]   <= 0;
            end else if (run[i]) begin
                k[i] <= k[i] + 1;
                if (k[i] < npx[i]) begin
                    e_wr[i] <= 1'b1;
                    e_x[i]  <= 8'(i * 40 + k[i]);
                    e_y[i]  <= 7'(i * 10 + k[i]);
                    e_c[i]  <= ctab[i][k[i]];
                    if (dlast[i] && k[i] == npx[i] - 1) begin
                        e_dn[i] <= 1'b1;
                        run[i]  <= 1'b0;
                    end
                end else if (!hang[i]) begin
                    e_dn[i] <= 1'b1;
                    run[i]  <= 1'b0;
                end
            end
        end
    end

    // output log
    pix_t          wq[$];
    logic [NL-1:0] sl[$];
    int            sc[$];
    always @(negedge clk) begin
        if (bus.writeEn) wq.push_back({bus.x, bus.y, bus.colour});
        if (|bus.layer_start) begin
            sl.push_back(bus.layer_start);
            sc.push_back(cyc);
        end
    end

    function automatic pix_t expx(input int i, input int kk);
        return {8'(i * 40 + kk), 7'(i * 10 + kk), ctab[i][kk]};
    endfunction

    task automatic clear_log();
        wq.delete();
        sl.delete();
        sc.delete();
    endtask

    task automatic cfg_default();
        for (int i = 0; i < NL; i++) begin
            npx[i] = 3; hang[i] = 1'b0; dlast[i] = 1'b0;
            for (int j = 0; j < 8; j++) ctab[i][j] = 8'(8'h10 + i * 8 + j);
        end
    endtask

    task automatic wait_done(output int dc);
        int t;
        dc = -1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL frame_done: done=%b after %0d cycles, required 1", done, t);
        end
    endtask

    task automatic end_frame();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_idle: busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic check_pixels(input string nm, input pix_t exp[$]);
        checks++;
        if (wq.size() != exp.size()) begin
            errors++;
            $display("FAIL %s_count: writes=%0d required %0d", nm, wq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (wq[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_px%0d: got %h required %h", nm, i, wq[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, bus.writeEn, bus.x, bus.y, bus.colour, bus.layer_start, active_layer, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b wen=%b x=%h y=%h c=%h ls=%b al=%0d te=%b required all 0",
                     busy, done, bus.writeEn, bus.x, bus.y, bus.colour, bus.layer_start, active_layer, timeout_err);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pix_t exp[$];
        int dc;
        cfg_default();
        clear_log();
        layer_en = 4'b0101;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, bus.layer_start} !== 5'b1_0000) begin
            errors++;
            $display("FAIL basic_scan: busy=%b ls=%b required 1/0000", busy, bus.layer_start);
        end
        layer_en = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus.layer_start !== 4'b0001) begin
            errors++;
            $display("FAIL basic_launch_lat: ls=%b required 0001", bus.layer_start);
        end
        wait_done(dc);
        checks++;
        if (sl.size() != 2 || sl[0] !== 4'b0001 || sl[1] !== 4'b0100) begin
            errors++;
            $display("FAIL basic_starts: n=%0d first=%b second=%b required 2/0001/0100",
                     sl.size(), (sl.size() > 0) ? sl[0] : 4'hx, (sl.size() > 1) ? sl[1] : 4'hx);
        end else begin
            checks++;
            if (sc[1] - sc[0] != 6) begin
                errors++;
                $display("FAIL basic_relaunch_gap: %0d required 6", sc[1] - sc[0]);
            end
        end
        for (int j = 0; j < 3; j++) exp.push_back(expx(0, j));
        for (int j = 0; j < 3; j++) exp.push_back(expx(2, j));
        check_pixels("basic", exp);
        checks++;
        if (timeout_err !== 4'b0000) begin
            errors++;
            $display("FAIL basic_timeout_err: %b required 0000", timeout_err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_hold: done=%b required 1", done);
        end
        end_frame();
    endtask

    task automatic test_key();
        pix_t exp[$];
        int dc;
        cfg_default();
        npx[0] = 1; ctab[0][0] = 8'h09;
        npx[1] = 4;
        ctab[1][0] = 8'h09; ctab[1][1] = 8'h21; ctab[1][2] = 8'h09; ctab[1][3] = 8'h23;
        clear_log();
        layer_en = 4'b0011;
        start = 1'b1;
        wait_done(dc);
        exp.push_back(expx(0, 0));
        exp.push_back(expx(1, 1));
        exp.push_back(expx(1, 3));
        check_pixels("key", exp);
        end_frame();
    endtask

    task automatic test_empty();
        clear_log();
        layer_en = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL empty_n1: busy/done=%b required 10", {busy, done});
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL empty_n2: busy/done=%b required 01", {busy, done});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || sl.size() != 0) begin
            errors++;
            $display("FAIL empty_hold: done=%b starts=%0d required 1/0", done, sl.size());
        end
        end_frame();
    endtask

    task automatic test_timeout();
        pix_t exp[$];
        int dc;
        cfg_default();
        npx[0] = 2;
        npx[1] = 2; hang[1] = 1'b1;
        clear_log();
        layer_en = 4'b0011;
        start = 1'b1;
        wait_done(dc);
        checks++;
        if (timeout_err !== 4'b0010) begin
            errors++;
            $display("FAIL tmo_flags: %b required 0010", timeout_err);
        end
        checks++;
        if (sl.size() != 2) begin
            errors++;
            $display("FAIL tmo_starts: n=%0d required 2", sl.size());
        end else begin
            checks++;
            if (dc - sc[1] != 18) begin
                errors++;
                $display("FAIL tmo_abandon_time: %0d required 18", dc - sc[1]);
            end
        end
        for (int j = 0; j < 2; j++) exp.push_back(expx(0, j));
        for (int j = 0; j < 2; j++) exp.push_back(expx(1, j));
        check_pixels("tmo", exp);
        end_frame();
        checks++;
        if (timeout_err !== 4'b0010) begin
            errors++;
            $display("FAIL tmo_sticky: %b required 0010", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int t, dc;
        cfg_default();
        npx[0] = 1; npx[1] = 1; npx[2] = 6;
        clear_log();
        layer_en = 4'b0111;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (timeout_err !== 4'b0000) begin
            errors++;
            $display("FAIL rst_err_clear: %b required 0000", timeout_err);
        end
        for (t = 0; t < 100 && sl.size() < 3; t++) @(negedge clk);
        checks++;
        if (sl.size() < 3) begin
            errors++;
            $display("FAIL rst_reach_l2: starts=%0d required 3", sl.size());
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.writeEn !== 1'b1 || active_layer !== 2'd2) begin
            errors++;
            $display("FAIL rst_pre_draw: wen=%b al=%0d required 1/2", bus.writeEn, active_layer);
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, bus.writeEn, bus.x, bus.y, bus.colour, bus.layer_start, active_layer, timeout_err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b wen=%b x=%h y=%h c=%h ls=%b al=%0d required all 0",
                     busy, done, bus.writeEn, bus.x, bus.y, bus.colour, bus.layer_start, active_layer);
        end
        reset = 1'b0;
        npx[2] = 1;
        @(negedge clk);
        clear_log();
        start = 1'b1;
        wait_done(dc);
        checks++;
        if (sl.size() != 3 || sl[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rst_redraw: starts=%0d first=%b required 3/0001",
                     sl.size(), (sl.size() > 0) ? sl[0] : 4'hx);
        end
        end_frame();
    endtask

    task automatic test_back_to_back();
        pix_t exp[$];
        int dc;
        cfg_default();
        npx[0] = 2; dlast[0] = 1'b1;
        npx[1] = 1;
        clear_log();
        layer_en = 4'b0011;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray_dn = 4'b0001;
        @(negedge clk);
        stray_dn = 4'b0100;
        stray_wr = 4'b1000;
        @(negedge clk);
        stray_dn = '0;
        stray_wr = '0;
        wait_done(dc);
        checks++;
        if (sl.size() != 2) begin
            errors++;
            $display("FAIL b2b_starts: n=%0d required 2", sl.size());
        end else begin
            checks++;
            if (sc[1] - sc[0] != 4) begin
                errors++;
                $display("FAIL b2b_relaunch_gap: %0d required 4", sc[1] - sc[0]);
            end
        end
        exp.push_back(expx(0, 0));
        exp.push_back(expx(0, 1));
        exp.push_back(expx(1, 0));
        check_pixels("b2b", exp);
        end_frame();
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            e_x[i] = '0; e_y[i] = '0; e_c[i] = '0;
            run[i] = 1'b0; k[i] = 0;
        end
        cfg_default();
        test_reset();
        test_basic();
        test_key();
        test_empty();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
